// File: rtl/y86_pkg.sv
// Shared Y86-64 decode constants: instruction codes, special register IDs,
// the E-stage bubble value and a register-ID legality helper.
package y86_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  localparam logic       BUBBLE_VALID = 1'b0;
  localparam logic [3:0] BUBBLE_ICODE = I_NOP;
  localparam logic [3:0] BUBBLE_DST   = RNONE;

  // True when the ID names an implemented register (RNONE is never one).
  function automatic logic reg_ok(input logic [3:0] id, input int num_regs);
    return (id != RNONE) && (int'(id) < num_regs);
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86 register file: two write ports (M beats E on collision) and two
// combinational read ports with write-through bypass.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int              DATA_W   = 64,
  parameter int              NUM_REGS = 15,
  parameter logic [DATA_W-1:0] SP_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        src_a,
  input  logic [3:0]        src_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  input  logic              w_en_e,
  input  logic [3:0]        w_dst_e,
  input  logic [DATA_W-1:0] w_val_e,
  input  logic              w_en_m,
  input  logic [3:0]        w_dst_m,
  input  logic [DATA_W-1:0] w_val_m
);

  // Sixteen slots so every 4-bit ID indexes cleanly; slots at or above
  // NUM_REGS are never written and stay at their reset value of zero.
  logic [DATA_W-1:0] regs_q [16];
  logic [DATA_W-1:0] regs_d [16];

  logic we_e, we_m;
  assign we_e = w_en_e && reg_ok(w_dst_e, NUM_REGS);
  assign we_m = w_en_m && reg_ok(w_dst_m, NUM_REGS);

  // NOTE: every always_comb output gets a full default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    regs_d = regs_q;
    if (we_e) regs_d[w_dst_e] = w_val_e;
    if (we_m) regs_d[w_dst_m] = w_val_m;
  end

  // NOTE: the array is reset explicitly because %rsp must start at SP_INIT; sequential state uses <= only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= (i == int'(RSP)) ? SP_INIT : '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [3:0]        src,
    input logic              en_m,
    input logic [3:0]        dst_m,
    input logic [DATA_W-1:0] val_m,
    input logic              en_e,
    input logic [3:0]        dst_e,
    input logic [DATA_W-1:0] val_e,
    input logic [DATA_W-1:0] stored
  );
    if (!reg_ok(src, NUM_REGS))      return '0;
    else if (en_m && dst_m == src)   return val_m;
    else if (en_e && dst_e == src)   return val_e;
    else                             return stored;
  endfunction

  assign rd_a = read_port(src_a, we_m, w_dst_m, w_val_m, we_e, w_dst_e, w_val_e, regs_q[src_a]);
  assign rd_b = read_port(src_b, we_m, w_dst_m, w_val_m, we_e, w_dst_e, w_val_e, regs_q[src_b]);

endmodule

// File: rtl/decode_regfile.sv
// Y86 decode stage: source/destination selection, register-file read and
// the E pipeline register with stall/bubble control.
module decode_regfile
  import y86_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter int                NUM_REGS = 15,
  parameter logic [DATA_W-1:0] SP_INIT  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [DATA_W-1:0] valP,
  input  logic              w_en_e,
  input  logic [3:0]        w_dst_e,
  input  logic [DATA_W-1:0] w_val_e,
  input  logic              w_en_m,
  input  logic [3:0]        w_dst_m,
  input  logic [DATA_W-1:0] w_val_m,
  input  logic              e_stall,
  input  logic              e_bubble,
  output logic              e_valid,
  output logic [3:0]        e_icode,
  output logic [DATA_W-1:0] e_valA,
  output logic [DATA_W-1:0] e_valB,
  output logic [3:0]        e_dstE,
  output logic [3:0]        e_dstM
);

  logic [3:0]        src_a, src_b, dst_e, dst_m;
  logic [DATA_W-1:0] rd_a, rd_b, val_a;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      I_RRMOVQ: begin src_a = rA;  dst_e = rB; end
      I_IRMOVQ: begin dst_e = rB; end
      I_RMMOVQ: begin src_a = rA;  src_b = rB; end
      I_MRMOVQ: begin src_b = rB;  dst_m = rA; end
      I_OPQ:    begin src_a = rA;  src_b = rB;  dst_e = rB; end
      I_CALL:   begin src_b = RSP; dst_e = RSP; end
      I_RET:    begin src_a = RSP; src_b = RSP; dst_e = RSP; end
      I_PUSHQ:  begin src_a = rA;  src_b = RSP; dst_e = RSP; end
      I_POPQ:   begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = rA; end
      default:  ;
    endcase
  end

  // Jumps and calls carry the fall-through PC down the pipe in valA.
  assign val_a = (icode == I_JXX || icode == I_CALL) ? valP : rd_a;

  y86_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .SP_INIT  (SP_INIT)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .src_a   (src_a),
    .src_b   (src_b),
    .rd_a    (rd_a),
    .rd_b    (rd_b),
    .w_en_e  (w_en_e),
    .w_dst_e (w_dst_e),
    .w_val_e (w_val_e),
    .w_en_m  (w_en_m),
    .w_dst_m (w_dst_m),
    .w_val_m (w_val_m)
  );

  logic              e_valid_q, e_valid_d;
  logic [3:0]        e_icode_q, e_icode_d;
  logic [DATA_W-1:0] e_val_a_q, e_val_a_d;
  logic [DATA_W-1:0] e_val_b_q, e_val_b_d;
  logic [3:0]        e_dst_e_q, e_dst_e_d;
  logic [3:0]        e_dst_m_q, e_dst_m_d;

  always_comb begin
    e_valid_d = e_valid_q;
    e_icode_d = e_icode_q;
    e_val_a_d = e_val_a_q;
    e_val_b_d = e_val_b_q;
    e_dst_e_d = e_dst_e_q;
    e_dst_m_d = e_dst_m_q;
    if (e_bubble || (!e_stall && !d_valid)) begin
      e_valid_d = BUBBLE_VALID;
      e_icode_d = BUBBLE_ICODE;
      e_val_a_d = '0;
      e_val_b_d = '0;
      e_dst_e_d = BUBBLE_DST;
      e_dst_m_d = BUBBLE_DST;
    end else if (!e_stall) begin
      e_valid_d = 1'b1;
      e_icode_d = icode;
      e_val_a_d = val_a;
      e_val_b_d = rd_b;
      e_dst_e_d = dst_e;
      e_dst_m_d = dst_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid_q <= BUBBLE_VALID;
      e_icode_q <= BUBBLE_ICODE;
      e_val_a_q <= '0;
      e_val_b_q <= '0;
      e_dst_e_q <= BUBBLE_DST;
      e_dst_m_q <= BUBBLE_DST;
    end else begin
      e_valid_q <= e_valid_d;
      e_icode_q <= e_icode_d;
      e_val_a_q <= e_val_a_d;
      e_val_b_q <= e_val_b_d;
      e_dst_e_q <= e_dst_e_d;
      e_dst_m_q <= e_dst_m_d;
    end
  end

  assign e_valid = e_valid_q;
  assign e_icode = e_icode_q;
  assign e_valA  = e_val_a_q;
  assign e_valB  = e_val_b_q;
  assign e_dstE  = e_dst_e_q;
  assign e_dstM  = e_dst_m_q;

endmodule
